dmem_access_fsm: RTL

// Memory-stage sequencer sitting directly upstream of the data-memory byte-lane controller.
// - Accepts one load/store request at a time from EX over a valid/ready handshake.
// - Checks alignment, range and funct3 legality, then drives the controller's mem_* inputs.
// - Waits out the SRAM read latency, captures the formatted load data and returns a

---
 rtl/dmem_access_fsm.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_fsm.sv
// dmem_access_fsm
// Memory-stage sequencer in front of the data-memory byte-lane controller.
// Takes one load/store at a time from EX (valid/ready), screens it for
// illegal funct3, out-of-range and misaligned addresses, drives the
// controller's mem_* strobes for one access cycle, waits out the SRAM read
// latency, and returns a response (load data or exception) to writeback
// over a second valid/ready handshake.
//
// Ports
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   ex_valid/ex_ready           request handshake; ex_ready high only in IDLE
//   ex_read, ex_write           request is a load / store
//   ex_funct3, ex_addr          RV32I load/store funct3, byte address
//   ex_wdata, ex_rd             unshifted store data, load destination register
//   mem_funct3, mem_byte_addr,
//   mem_MuxDataB                latched request fields to the controller
//   mem_MemEn, mem_MemWrite,
//   mem_MemRead                 access strobe, write enable, read enable
//   mem_ReadData                formatted load data from the controller
//   resp_valid/resp_ready       response handshake
//   resp_is_load, resp_rd       response belongs to a load, its destination
//   resp_data                   load data (0 for stores and exceptions)
//   resp_exc, resp_cause        fault flag and cause (00 range, 01 load
//                               misaligned, 10 store misaligned, 11 illegal)
module dmem_access_fsm #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_read,
  input  logic              ex_write,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_byte_addr,
  output logic [31:0]       mem_MuxDataB,
  output logic              mem_MemEn,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [31:0]       mem_ReadData,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_is_load,
  output logic [4:0]        resp_rd,
  output logic [31:0]       resp_data,
  output logic              resp_exc,
  output logic [1:0]        resp_cause
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t      state;
  logic [1:0]  cnt;
  logic        mem_en_q;
  logic        mem_write_q;
  logic        mem_read_q;
  logic        resp_valid_q;

  logic        req;
  logic        illegal;
  logic        out_of_range;
  logic        misaligned;
  logic        fault;
  logic [1:0]  cause;

  // Request screening, evaluated on the live ex_* inputs in the accept cycle.
  always_comb begin
    req          = ex_valid & (ex_read | ex_write);
    illegal      = (ex_read & ex_write)
                 | (ex_read  & ((ex_funct3 == 3'd3) | (ex_funct3 == 3'd6) | (ex_funct3 == 3'd7)))
                 | (ex_write & (ex_funct3 > 3'd2));
    out_of_range = |ex_addr[31:ADDR_W];
    // funct3[1:0] encodes access size: 00 byte, 01 half, 10 word.
    misaligned   = ((ex_funct3[1:0] == 2'b01) & ex_addr[0])
                 | ((ex_funct3[1:0] == 2'b10) & (|ex_addr[1:0]));
    fault        = illegal | out_of_range | misaligned;
    cause        = 2'b00;
    if (illegal)
      cause = 2'b11;
    else if (out_of_range)
      cause = 2'b00;
    else if (misaligned)
      cause = ex_read ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      mem_en_q      <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      mem_funct3    <= '0;
      mem_byte_addr <= '0;
      mem_MuxDataB  <= '0;
      resp_is_load  <= 1'b0;
      resp_rd       <= '0;
      resp_data     <= '0;
      resp_exc      <= 1'b0;
      resp_cause    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            mem_funct3    <= ex_funct3;
            mem_byte_addr <= ex_addr[ADDR_W-1:0];
            mem_MuxDataB  <= ex_wdata;
            resp_is_load  <= ex_read;
            resp_rd       <= ex_rd;
            resp_data     <= '0;
            resp_exc      <= fault;
            resp_cause    <= fault ? cause : 2'b00;
            if (fault) begin
              resp_valid_q <= 1'b1;
              state        <= S_DONE;
            end else begin
              mem_en_q    <= 1'b1;
              mem_write_q <= ex_write;
              mem_read_q  <= ex_read;
              state       <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          mem_en_q    <= 1'b0;
          mem_write_q <= 1'b0;
          if (resp_is_load) begin
            mem_read_q <= 1'b1;
            cnt        <= CNT_INIT;
            state      <= S_WAIT;
          end else begin
            mem_read_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_WAIT: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            resp_data    <= mem_ReadData;
            mem_read_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are registered but also gated by rst so an access in flight is
  // killed in the same cycle reset is raised (no partial write).
  always_comb begin
    ex_ready     = (state == S_IDLE) & ~rst;
    mem_MemEn    = mem_en_q & ~rst;
    mem_MemWrite = mem_write_q & ~rst;
    mem_MemRead  = mem_read_q & ~rst;
    resp_valid   = resp_valid_q & ~rst;
  end

endmodule
